fetch_sequencer: RTL and testbench

//  Instruction-fetch and PC-sequencing stage directly upstream of the 8-bit datapath.

---
 rtl/fetch_pkg.sv | 56 +++++
 rtl/ret_stack.sv | 58 +++++
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared opcode, condition-code and FSM encodings for the fetch sequencer,
// plus helpers that decode control-flow instructions.
package fetch_pkg;

  localparam int ISA_W = 19;
  localparam int TGT_W = 12;

  localparam logic [2:0] OP_BRANCH = 3'd5;
  localparam logic [2:0] OP_JUMP   = 3'd7;

  localparam logic [1:0] COND_Z  = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_C  = 2'b10;
  localparam logic [1:0] COND_NC = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_CTRL  = 2'd3;

  typedef struct packed {
    logic             is_branch;
    logic             is_call;
    logic             is_ret;
    logic [1:0]       cond;
    logic [7:0]       offset;
    logic [TGT_W-1:0] target;
  } ctrl_t;

  function automatic logic is_ctrl_op(input logic [2:0] op);
    return (op == OP_BRANCH) || (op == OP_JUMP);
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [ISA_W-1:0] ins);
    ctrl_t d;
    d.is_branch = (ins[18:16] == OP_BRANCH);
    d.is_call   = (ins[18:16] == OP_JUMP) && !ins[15] && ins[14];
    d.is_ret    = (ins[18:16] == OP_JUMP) && ins[15];
    d.cond      = ins[15:14];
    d.offset    = ins[7:0];
    d.target    = ins[11:0];
    return d;
  endfunction

  function automatic logic cond_met(input logic [1:0] cond, input logic z, input logic c);
    logic r;
    case (cond)
      COND_Z:  r = z;
      COND_NZ: r = !z;
      COND_C:  r = c;
      default: r = !c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses; push on full and pop on empty are ignored so the
// caller can flag them. Top is combinational from the current fill level.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_dat_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] top_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;
  assign wr_idx  = cnt_q[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign top_o   = mem_q[top_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (do_pop) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entries beyond the fill level are never read, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= push_dat_i;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/PC-sequencing stage: fetches over req/ack, resolves branch/jump/call/ret locally.
// imem_ack -> instr_valid in 1 cycle; while instr_ready is low instr is held and no fetch is issued.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              PC_W        = 12,
  parameter int              INSTR_W     = 19,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               flag_z,
  input  logic               flag_c,
  input  logic               flags_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               stack_ovf,
  output logic               stack_unf
);

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_tgt;
  ctrl_t              dec;

  logic               stk_push;
  logic               stk_pop;
  logic               stk_full;
  logic               stk_empty;
  logic [PC_W-1:0]    stk_top;

  assign dec    = decode_ctrl(instr_q);
  assign pc_inc = pc_q + PC_W'(1);
  // Offset is unsigned and relative to the following instruction; both adds wrap.
  assign pc_tgt = pc_inc + PC_W'(dec.offset);

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_ISSUE);
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk        (clk),
    .rst        (rst),
    .push_i     (stk_push),
    .pop_i      (stk_pop),
    .push_dat_i (pc_inc),
    .full_o     (stk_full),
    .empty_o    (stk_empty),
    .top_o      (stk_top)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = is_ctrl_op(imem_data[INSTR_W-1 -: 3]) ? ST_CTRL : ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (instr_ready) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end

      ST_CTRL: begin
        if (dec.is_branch) begin
          // Flags may still lag instructions already handed downstream.
          if (flags_valid) begin
            pc_d    = cond_met(dec.cond, flag_z, flag_c) ? pc_tgt : pc_inc;
            state_d = ST_FETCH;
          end
        end else if (dec.is_ret) begin
          if (stk_empty) begin
            unf_d = 1'b1;
            pc_d  = pc_inc;
          end else begin
            stk_pop = 1'b1;
            pc_d    = stk_top;
          end
          state_d = ST_FETCH;
        end else begin
          if (dec.is_call) begin
            if (stk_full) begin
              ovf_d = 1'b1;
            end else begin
              stk_push = 1'b1;
            end
          end
          pc_d    = PC_W'(dec.target);
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed table of single control instructions, hand-written
// multi-cycle sequences, and a random program checked against an instruction-level model.
module tb_fetch_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [18:0] imem_data = '0;
  logic        flag_z = 1'b0;
  logic        flag_c = 1'b0;
  logic        flags_valid = 1'b0;
  logic [18:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        stack_ovf;
  logic        stack_unf;

  fetch_sequencer #(
    .PC_W        (12),
    .INSTR_W     (19),
    .STACK_DEPTH (DEPTH),
    .RESET_PC    (12'h000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flags_valid (flags_valid),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc;
    logic [18:0] ins;
    logic        z;
    logic        c;
    logic [11:0] nxt;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t        tbl [11];
  logic [18:0] mem [4096];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  bit          rand_mode = 0;
  bit          ack_en = 1;
  bit          force_ack = 0;
  logic        dir_ready = 1'b1;
  logic        dir_fv = 1'b1;
  logic        dir_z = 1'b0;
  logic        dir_c = 1'b0;
  int          dir_delay = 0;
  int          wcnt = 0;
  int          cur_delay = 0;

  logic [11:0] fetch_q [$];
  logic [18:0] issue_q [$];
  int          lat_q [$];
  int          ack_cyc = 0;
  logic        prev_valid = 1'b0;
  int          bad_issue = 0;

  logic [11:0] m_pc = '0;
  logic [11:0] m_stack [$];
  logic [18:0] exp_issue [$];
  bit          m_ovf = 0;
  bit          m_unf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction-level reference: one call per fetched word, from the program image.
  task automatic model_fetch(input logic [11:0] addr);
    logic [18:0] ins;
    logic        tk;
    chk("rand fetch addr", 32'(addr), 32'(m_pc));
    ins = mem[m_pc];
    if (ins[18:16] == 3'd5) begin
      case (ins[15:14])
        2'b00:   tk = flag_z;
        2'b01:   tk = !flag_z;
        2'b10:   tk = flag_c;
        default: tk = !flag_c;
      endcase
      m_pc = tk ? 12'((int'(m_pc) + 1 + int'(ins[7:0])) % 4096) : 12'((int'(m_pc) + 1) % 4096);
    end else if (ins[18:16] == 3'd7) begin
      if (!ins[15]) begin
        if (ins[14]) begin
          if (m_stack.size() < DEPTH) m_stack.push_back(12'((int'(m_pc) + 1) % 4096));
          else m_ovf = 1;
        end
        m_pc = ins[11:0];
      end else if (m_stack.size() == 0) begin
        m_unf = 1;
        m_pc  = 12'((int'(m_pc) + 1) % 4096);
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else begin
      exp_issue.push_back(ins);
      m_pc = 12'((int'(m_pc) + 1) % 4096);
    end
  endtask

  always @(posedge clk) cyc++;

  // Single driver of all DUT inputs except rst, plus the observation monitor.
  always @(negedge clk) begin
    logic [18:0] want;
    if (rand_mode) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      flags_valid = ($urandom_range(0, 3) != 0);
    end else begin
      instr_ready = dir_ready;
      flags_valid = dir_fv;
      flag_z      = dir_z;
      flag_c      = dir_c;
    end
    if (force_ack) begin
      imem_ack  = 1'b1;
      imem_data = 19'h7FFFF;
    end else if (imem_req && ack_en) begin
      if (wcnt >= cur_delay) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        wcnt      = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack  = 1'b0;
      wcnt      = 0;
      cur_delay = rand_mode ? int'($urandom_range(0, 2)) : dir_delay;
    end
    if (rst && imem_req && imem_ack && !force_ack) begin
      fetch_q.push_back(imem_addr);
      ack_cyc = cyc;
      if (rand_mode) model_fetch(imem_addr);
    end
    if (instr_valid && !prev_valid) lat_q.push_back(cyc - ack_cyc);
    prev_valid = instr_valid;
    if (instr_valid && instr_ready) begin
      if (instr[18:16] == 3'd5 || instr[18:16] == 3'd7) bad_issue++;
      issue_q.push_back(instr);
      if (rand_mode) begin
        want = (exp_issue.size() != 0) ? exp_issue.pop_front() : 19'h7FFFF;
        chk("rand issued instr", 32'(instr), 32'(want));
        flag_z = 1'($urandom);
        flag_c = 1'($urandom);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    fetch_q.delete();
    issue_q.delete();
    lat_q.delete();
    exp_issue.delete();
    m_stack.delete();
    bad_issue = 0;
    m_pc  = '0;
    m_ovf = 0;
    m_unf = 0;
    #1 rst = 1'b1;
  endtask

  task automatic wait_fetch(input int n, input string name);
    int k = 0;
    while (fetch_q.size() < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (fetch_q.size() < n) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: got %0d fetches, expected %0d", name, fetch_q.size(), n);
    end
  endtask

  task automatic fill_default();
    for (int a = 0; a < 4096; a++) mem[a] = {3'd1, 4'd0, 12'(a)};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{12'h010, 19'h50004, 1'b1, 1'b0, 12'h015, 1'b0, 1'b0};
    tbl[1]  = '{12'h010, 19'h50004, 1'b0, 1'b0, 12'h011, 1'b0, 1'b0};
    tbl[2]  = '{12'h010, 19'h54004, 1'b0, 1'b0, 12'h015, 1'b0, 1'b0};
    tbl[3]  = '{12'h010, 19'h54004, 1'b1, 1'b0, 12'h011, 1'b0, 1'b0};
    tbl[4]  = '{12'h030, 19'h58010, 1'b0, 1'b1, 12'h041, 1'b0, 1'b0};
    tbl[5]  = '{12'h030, 19'h5C010, 1'b0, 1'b1, 12'h031, 1'b0, 1'b0};
    tbl[6]  = '{12'hFFE, 19'h500FF, 1'b1, 1'b0, 12'h0FE, 1'b0, 1'b0};
    tbl[7]  = '{12'h050, 19'h70123, 1'b0, 1'b0, 12'h123, 1'b0, 1'b0};
    tbl[8]  = '{12'h020, 19'h74200, 1'b0, 1'b0, 12'h200, 1'b0, 1'b0};
    tbl[9]  = '{12'h040, 19'h78000, 1'b0, 1'b0, 12'h041, 1'b0, 1'b1};
    tbl[10] = '{12'hFFF, 19'h10ABC, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};

    fill_default();
    #1 rst = 1'b0;
    #11;
    chk("reset imem_req", 32'(imem_req), 32'd0);
    chk("reset instr_valid", 32'(instr_valid), 32'd0);
    chk("reset instr", 32'(instr), 32'd0);
    chk("reset stack_ovf", 32'(stack_ovf), 32'd0);
    chk("reset stack_unf", 32'(stack_unf), 32'd0);

    // In-order issue of straight-line code with a one-cycle memory.
    mem[0] = 19'h00011;
    mem[1] = 19'h20022;
    mem[2] = 19'h40033;
    dir_delay = 1;
    do_reset();
    wait_fetch(4, "seq");
    chk("seq fetch0", 32'(fetch_q[0]), 32'h000);
    chk("seq fetch1", 32'(fetch_q[1]), 32'h001);
    chk("seq fetch2", 32'(fetch_q[2]), 32'h002);
    chk("seq issue0", 32'(issue_q[0]), 32'h00011);
    chk("seq issue1", 32'(issue_q[1]), 32'h20022);
    chk("seq issue2", 32'(issue_q[2]), 32'h40033);
    for (int i = 0; i < 3; i++) chk($sformatf("seq latency%0d", i), 32'(lat_q[i]), 32'd1);
    dir_delay = 0;

    // One control instruction reached through a plain jump from address 0.
    for (int i = 0; i < 11; i++) begin
      fill_default();
      mem[0] = {7'b1110000, tbl[i].pc};
      mem[tbl[i].pc] = tbl[i].ins;
      dir_z = tbl[i].z;
      dir_c = tbl[i].c;
      do_reset();
      wait_fetch(3, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d next fetch", i), 32'(fetch_q[2]), 32'(tbl[i].nxt));
      chk($sformatf("vec%0d stack_ovf", i), 32'(stack_ovf), 32'(tbl[i].ovf));
      chk($sformatf("vec%0d stack_unf", i), 32'(stack_unf), 32'(tbl[i].unf));
    end

    // Branch waits on flags_valid and does not fetch meanwhile.
    fill_default();
    mem[0] = 19'h70010;
    mem[12'h010] = 19'h50004;
    dir_z = 1'b1;
    dir_fv = 1'b0;
    do_reset();
    wait_fetch(2, "fv wait");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("fv low no req%0d", i), 32'(imem_req), 32'd0);
    end
    dir_fv = 1'b1;
    wait_fetch(3, "fv release");
    chk("fv branch target", 32'(fetch_q[2]), 32'h015);

    // CALL then RET: neither is handed downstream.
    fill_default();
    mem[0] = 19'h70020;
    mem[12'h020] = 19'h74200;
    mem[12'h200] = 19'h78000;
    do_reset();
    wait_fetch(4, "call/ret");
    chk("call fetch target", 32'(fetch_q[2]), 32'h200);
    chk("ret fetch return", 32'(fetch_q[3]), 32'h021);
    chk("call/ret never issued", 32'(bad_issue), 32'd0);

    // DEPTH+1 nested calls: last push dropped, jump still taken.
    fill_default();
    mem[0] = 19'h70100;
    for (int k = 0; k <= DEPTH; k++) mem[12'h100 + k] = {7'b1110100, 12'(12'h101 + k)};
    do_reset();
    wait_fetch(10, "nest");
    chk("nest ovf before last", 32'(stack_ovf), 32'd0);
    wait_fetch(11, "nest last");
    chk("nest last target", 32'(fetch_q[10]), 32'h109);
    chk("nest stack_ovf", 32'(stack_ovf), 32'd1);
    chk("nest stack_unf", 32'(stack_unf), 32'd0);

    // Backpressure in ISSUE, then wrap of the PC past 0xFFF.
    fill_default();
    mem[0] = 19'h12345;
    dir_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 50 && !instr_valid; k++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold instr%0d", i), 32'(instr), 32'h12345);
      chk($sformatf("hold valid/no req%0d", i), 32'({instr_valid, imem_req}), 32'b10);
      @(posedge clk); #1;
    end
    dir_ready = 1'b1;
    wait_fetch(2, "hold release");
    chk("hold next fetch", 32'(fetch_q[1]), 32'h001);

    // Reset while a fetch is outstanding; acks outside FETCH are ignored.
    fill_default();
    ack_en = 0;
    do_reset();
    for (int k = 0; k < 20 && !imem_req; k++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    chk("rst drops imem_req", 32'(imem_req), 32'd0);
    force_ack = 1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("idle after reset no req", 32'(imem_req), 32'd0);
    chk("late ack ignored", 32'(instr), 32'd0);
    force_ack = 0;
    ack_en = 1;
    @(posedge clk); #1;
    chk("refetch addr", 32'({imem_req, imem_addr}), 32'h1000);
    wait_fetch(1, "refetch");
    @(posedge clk); #1;
    chk("refetch instr", 32'(instr), 32'h10000);

    // Random program against the instruction-level model.
    for (int a = 0; a < 4096; a++) begin
      int r;
      logic [2:0] op;
      r  = int'($urandom_range(0, 99));
      op = ($urandom_range(0, 5) == 5) ? 3'd6 : 3'($urandom_range(0, 4));
      if (r < 60)      mem[a] = {op, 16'($urandom)};
      else if (r < 75) mem[a] = {3'd5, 16'($urandom)};
      else if (r < 90) mem[a] = {3'd7, 1'b0, 1'($urandom), 2'b00, 12'($urandom)};
      else             mem[a] = {3'd7, 1'b1, 15'($urandom)};
    end
    rand_mode = 1;
    do_reset();
    wait_fetch(400, "random");
    rand_mode = 0;
    chk("rand stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    chk("rand stack_unf", 32'(stack_unf), 32'(m_unf));
    chk("rand ctrl never issued", 32'(bad_issue), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
